onehot_addr_guard: RTL and testbench
====================================

ONEHOT_ADDR_GUARD -- requirements
Module: onehot_addr_guard

Interface
REQ-001 Parameter AddrWidth, default 5, width of binary address.
REQ-002 Parameter OneHotWidth, default 2**AddrWidth, one-hot vector width; SHALL satisfy 1 < OneHotWidth <= 2**AddrWidth, elaboration error otherwise.
REQ-003 Parameter AddrCheck, default 1, enables address-consistency check.
REQ-004 Parameter EnableCheck, default 1, enables enable-consistency check; AddrCheck=1 with EnableCheck=0 SHALL be an elaboration error.
REQ-005 clk_i  input  1  clock, rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 addr_i  input  AddrWidth  binary index to encode and check against.
REQ-008 en_i  input  1  encode/check enable.
REQ-009 oh_o  output  OneHotWidth  buffered one-hot encoding of addr_i.
REQ-010 oh_i  input  OneHotWidth  one-hot vector under check (normally oh_o fed back; may be driven independently for fault injection).
REQ-011 clr_i  input  1  synchronous clear of sticky error.
REQ-012 err_o  output  1  combinational error flag.
REQ-013 err_sticky_o  output  1  registered, sticky error flag.

Function
REQ-014 Encoder: enc[k] = en_i && (addr_i == k) for k in 0..OneHotWidth-1; en_i=0 or addr_i >= OneHotWidth SHALL give all-zero.
REQ-015 Buffer: oh_o SHALL equal enc bit-for-bit, zero latency, implemented as a distinct pass-through stage the synthesis flow must not merge with the checker.
REQ-016 Checker is purely combinational from oh_i, addr_i, en_i to err_o; zero latency.
REQ-017 oh_err: asserted when more than one bit of oh_i is set, regardless of parameters.
REQ-018 enable_err (EnableCheck=1 only): asserted when en_i=1 and oh_i is all-zero, or en_i=0 and any oh_i bit set; forced 0 when EnableCheck=0.
REQ-019 addr_err (AddrCheck=1 only): asserted when en_i=1 and oh_i[addr_i]=0, including addr_i >= OneHotWidth; forced 0 when AddrCheck=0.
REQ-020 err_o SHALL be oh_err OR enable_err OR addr_err.
REQ-021 err_sticky_o: on each rising clk_i, if clr_i=1 it SHALL load 0, else it SHALL load err_sticky_o OR err_o; clr_i has priority over a same-cycle err_o.
REQ-022 With oh_i tied to oh_o and addr_i < OneHotWidth, err_o SHALL be 0 for every addr_i and en_i value.
REQ-023 err_o is independent of clk_i and rst_ni; it SHALL be valid during reset.

Reset
REQ-024 rst_ni low SHALL clear err_sticky_o to 0 immediately, independent of clk_i, and hold it 0 while low.
REQ-025 Deassertion SHALL be sampled at a rising clk_i edge; the first capture of err_o occurs at the first edge after rst_ni is high.
REQ-026 oh_o and err_o have no reset state; they follow inputs at all times.

Verification
REQ-027 Defaults, en_i=1, addr_i=5'd7, oh_i=oh_o -> oh_o=32'h0000_0080, err_o=0, err_sticky_o stays 0.
REQ-028 en_i=0, addr_i=5'd3, oh_i=32'h0000_0008 -> oh_o=0, err_o=1 (enable_err); next edge err_sticky_o=1.
REQ-029 en_i=1, addr_i=5'd4, oh_i=32'h0000_0030 -> err_o=1 (oh_err); oh_i=32'h0000_0020 -> err_o=1 (addr_err); oh_i=32'h0000_0010 -> err_o=0.
REQ-030 en_i=1, oh_i=0, any addr_i -> err_o=1; with AddrCheck=0/EnableCheck=0 same stimulus -> err_o=0, while oh_i=32'h0000_0003 still -> err_o=1.
REQ-031 Sticky set, then clr_i=1 with err_o=1 at same edge -> err_sticky_o=0; clr_i=0 next edge -> 1 again; rst_ni pulsed low mid-cycle -> err_sticky_o=0 immediately.
REQ-032 OneHotWidth=24, AddrWidth=5, en_i=1, addr_i=5'd30, oh_i=oh_o -> oh_o=0, err_o=1.

Source files
------------

// File: rtl/onehot_addr_guard.sv
// Binary-to-one-hot encoder with a buffered output and an independent checker
// that flags inconsistencies between an external one-hot vector, the address and the enable.
module onehot_addr_guard #(
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned OneHotWidth = 2 ** AddrWidth,
  parameter bit          AddrCheck   = 1'b1,
  parameter bit          EnableCheck = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  output logic [OneHotWidth-1:0] oh_o,
  input  logic [OneHotWidth-1:0] oh_i,
  input  logic                   clr_i,
  output logic                   err_o,
  output logic                   err_sticky_o
);

  localparam int unsigned AddrSpan = 2 ** AddrWidth;

  // Reject parameter combinations that make the guard meaningless.
  if (OneHotWidth <= 1 || OneHotWidth > AddrSpan) begin : g_bad_width
    $error("onehot_addr_guard: OneHotWidth must satisfy 1 < OneHotWidth <= 2**AddrWidth");
  end
  if (AddrCheck && !EnableCheck) begin : g_bad_check
    $error("onehot_addr_guard: AddrCheck requires EnableCheck");
  end

  logic [OneHotWidth-1:0] dec;
  logic [OneHotWidth-1:0] enc;
  logic                   oh_err;
  logic                   enable_err;
  logic                   addr_err;

  // Address decode, independent of the enable; shared by encoder and address check.
  always_comb begin
    dec = '0;
    for (int unsigned k = 0; k < OneHotWidth; k++) begin
      dec[k] = (addr_i == AddrWidth'(k));
    end
  end

  assign enc = en_i ? dec : '0;

  // Output buffer kept as its own per-bit stage so the checker sees a separate copy.
  for (genvar g = 0; g < OneHotWidth; g++) begin : g_buf
    assign oh_o[g] = enc[g];
  end

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign oh_err = |(oh_i & (oh_i - OneHotWidth'(1)));

  always_comb begin
    enable_err = 1'b0;
    addr_err   = 1'b0;
    if (EnableCheck) begin
      enable_err = en_i ? ~(|oh_i) : (|oh_i);
    end
    if (AddrCheck) begin
      addr_err = en_i & ~(|(oh_i & dec));
    end
  end

  assign err_o = oh_err | enable_err | addr_err;

  // Sticky capture of err_o; clear wins over a same-cycle error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_sticky_o <= 1'b0;
    end else if (clr_i) begin
      err_sticky_o <= 1'b0;
    end else begin
      err_sticky_o <= err_sticky_o | err_o;
    end
  end

endmodule

// File: tb/tb_onehot_addr_guard.sv
// Self-checking bench: three guard configurations driven in parallel, checked
// every cycle against a behavioural model plus hand-computed directed checks.
module tb_onehot_addr_guard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addr;
  logic        en;
  logic        clr;
  logic        fb;
  logic [31:0] oh_force;

  logic [31:0] oh_o_a, oh_i_a, oh_o_b, oh_i_b;
  logic [23:0] oh_o_c, oh_i_c;
  logic        err_a, err_b, err_c, st_a, st_b, st_c;

  int checks = 0;
  int errors = 0;
  bit s_a, s_b, s_c;

  always #5 clk = ~clk;

  assign oh_i_a = fb ? oh_o_a : oh_force;
  assign oh_i_b = fb ? oh_o_b : oh_force;
  assign oh_i_c = fb ? oh_o_c : oh_force[23:0];

  onehot_addr_guard u_a (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .en_i(en), .oh_o(oh_o_a),
    .oh_i(oh_i_a), .clr_i(clr), .err_o(err_a), .err_sticky_o(st_a)
  );

  onehot_addr_guard #(.AddrCheck(1'b0), .EnableCheck(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .en_i(en), .oh_o(oh_o_b),
    .oh_i(oh_i_b), .clr_i(clr), .err_o(err_b), .err_sticky_o(st_b)
  );

  onehot_addr_guard #(.AddrWidth(5), .OneHotWidth(24)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .en_i(en), .oh_o(oh_o_c),
    .oh_i(oh_i_c), .clr_i(clr), .err_o(err_c), .err_sticky_o(st_c)
  );

  function automatic logic [31:0] mask_w(int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  // Expected one-hot: a single power of two when enabled and in range.
  function automatic logic [31:0] m_enc(int w);
    if (en && int'(addr) < w) return 32'(64'd1 << addr);
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_ohi(int w);
    return fb ? m_enc(w) : (oh_force & mask_w(w));
  endfunction

  function automatic bit m_err(int w, bit ac, bit ec);
    logic [31:0] oh;
    int n;
    bit e_oh, e_en, e_ad;
    oh   = m_ohi(w);
    n    = $countones(oh);
    e_oh = (n > 1);
    e_en = ec && (en ? (n == 0) : (n != 0));
    e_ad = ac && en && ((int'(addr) >= w) || (oh[addr] == 1'b0));
    return e_oh || e_en || e_ad;
  endfunction

  // Model of the sticky flags: what each DUT must have captured so far.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a <= 1'b0; s_b <= 1'b0; s_c <= 1'b0;
    end else if (clr) begin
      s_a <= 1'b0; s_b <= 1'b0; s_c <= 1'b0;
    end else begin
      s_a <= s_a | m_err(32, 1'b1, 1'b1);
      s_b <= s_b | m_err(32, 1'b0, 1'b0);
      s_c <= s_c | m_err(24, 1'b1, 1'b1);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model oh_o a", oh_o_a, m_enc(32));
    chk("model oh_o b", oh_o_b, m_enc(32));
    chk("model oh_o c", 32'(oh_o_c), m_enc(24));
    chk("model err a", 32'(err_a), 32'(m_err(32, 1'b1, 1'b1)));
    chk("model err b", 32'(err_b), 32'(m_err(32, 1'b0, 1'b0)));
    chk("model err c", 32'(err_c), 32'(m_err(24, 1'b1, 1'b1)));
    chk("model sticky a", 32'(st_a), 32'(s_a));
    chk("model sticky b", 32'(st_b), 32'(s_b));
    chk("model sticky c", 32'(st_c), 32'(s_c));
  end

  task automatic drive(int a, bit e, bit f, logic [31:0] ohf, bit c);
    @(posedge clk);
    #2;
    addr = 5'(a); en = e; fb = f; oh_force = ohf; clr = c;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; en = 1'b0; clr = 1'b0; fb = 1'b1; oh_force = '0;
    #1;
    chk("reset sticky", 32'(st_a), 32'd0);
    // err_o must be live during reset
    en = 1'b1; fb = 1'b0;
    #1;
    chk("err in reset", 32'(err_a), 32'd1);
    @(posedge clk);
    #1;
    chk("sticky held in reset", 32'(st_a), 32'd0);
    en = 1'b0; fb = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;

    drive(7, 1'b1, 1'b1, 32'd0, 1'b0);
    chk("addr7 oh_o", oh_o_a, 32'h0000_0080);
    chk("addr7 err", 32'(err_a), 32'd0);
    @(posedge clk); #1;
    chk("addr7 sticky", 32'(st_a), 32'd0);

    // Fed-back sweep: guard must stay quiet for every in-range address.
    for (int e = 0; e < 2; e++) begin
      for (int a = 0; a < 32; a++) drive(a, 1'(e), 1'b1, 32'd0, 1'b0);
    end
    chk("sweep sticky a", 32'(st_a), 32'd0);

    drive(3, 1'b0, 1'b0, 32'h0000_0008, 1'b0);
    chk("en0 oh_o", oh_o_a, 32'd0);
    chk("en0 err", 32'(err_a), 32'd1);
    @(posedge clk); #1;
    chk("en0 sticky", 32'(st_a), 32'd1);

    drive(4, 1'b1, 1'b0, 32'h0000_0030, 1'b0);
    chk("two-hot err", 32'(err_a), 32'd1);
    drive(4, 1'b1, 1'b0, 32'h0000_0020, 1'b0);
    chk("wrong-bit err", 32'(err_a), 32'd1);
    drive(4, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
    chk("right-bit err", 32'(err_a), 32'd0);

    drive(9, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("zero oh err a", 32'(err_a), 32'd1);
    chk("zero oh err b", 32'(err_b), 32'd0);
    drive(9, 1'b1, 1'b0, 32'h0000_0003, 1'b0);
    chk("two-hot err b", 32'(err_b), 32'd1);
    drive(0, 1'b0, 1'b0, 32'h8000_0001, 1'b0);
    chk("msb+lsb err b", 32'(err_b), 32'd1);

    // Clear has priority over an error in the same cycle.
    drive(9, 1'b1, 1'b0, 32'd0, 1'b1);
    @(posedge clk); #1;
    chk("clr priority", 32'(st_a), 32'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    chk("re-set sticky", 32'(st_a), 32'd1);

    // Asynchronous reset pulse away from the clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async clear", 32'(st_a), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    chk("after deassert", 32'(st_a), 32'd0);
    @(posedge clk); #1;
    chk("first capture", 32'(st_a), 32'd1);

    drive(30, 1'b1, 1'b1, 32'd0, 1'b1);
    chk("w24 oh_o", 32'(oh_o_c), 32'd0);
    chk("w24 err", 32'(err_c), 32'd1);
    drive(23, 1'b1, 1'b1, 32'd0, 1'b1);
    chk("w24 top oh_o", 32'(oh_o_c), 32'h0080_0000);
    chk("w24 top err", 32'(err_c), 32'd0);
    drive(23, 1'b1, 1'b1, 32'd0, 1'b0);
    drive(23, 1'b1, 1'b1, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
